// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
// Shares the single-ported synchronous system/video RAM between the video
// fetch engine (priority requester) and the 8080 CPU bus. A streak counter
// bounds how many video grants may pass a waiting CPU, and cpu_ready holds
// the 8080 in wait states until its access completes.
module ram_bus_arbiter #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk1,
   input  logic              clrn1,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned         STREAK_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_V_ADDR,
      S_V_DATA,
      S_C_ADDR,
      S_C_DATA
   } state_t;

   state_t              state_q,     state_d;
   logic [STREAK_W-1:0] streak_q,    streak_d;
   logic                vid_ack_q,   vid_ack_d;
   logic                cpu_ack_q,   cpu_ack_d;
   logic                ram_we_q,    ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   vid_data_q,  vid_data_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                cpu_wr_q,    cpu_wr_d;

   logic arb_edge;
   logic vid_elig;
   logic cpu_elig;
   logic grant_vid;
   logic grant_cpu;

   // Arbitration, access sequencing, data capture and streak bookkeeping.
   always_comb begin
      arb_edge = (state_q == S_IDLE) || (state_q == S_V_DATA) || (state_q == S_C_DATA);

      // A request is ignored in its own ack cycle, and the requester whose
      // access is completing on this edge cannot be re-granted on it.
      vid_elig = vid_req && !vid_ack_q && (state_q != S_V_DATA);
      cpu_elig = cpu_req && !cpu_ack_q && (state_q != S_C_DATA);

      grant_cpu = arb_edge && cpu_elig && ((streak_q == STREAK_MAX) || !vid_elig);
      grant_vid = arb_edge && vid_elig && !grant_cpu;

      state_d     = state_q;
      streak_d    = streak_q;
      vid_ack_d   = 1'b0;
      cpu_ack_d   = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      vid_data_d  = vid_data_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_wr_d    = cpu_wr_q;

      case (state_q)
         S_IDLE:   state_d = S_IDLE;
         S_V_ADDR: state_d = S_V_DATA;
         S_C_ADDR: state_d = S_C_DATA;
         S_V_DATA: begin
            vid_data_d = ram_rdata;
            vid_ack_d  = 1'b1;
            state_d    = S_IDLE;
         end
         S_C_DATA: begin
            if (!cpu_wr_q) begin
               cpu_rdata_d = ram_rdata;
            end
            cpu_ack_d = 1'b1;
            state_d   = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase

      if (grant_vid) begin
         ram_addr_d = vid_addr;
         state_d    = S_V_ADDR;
      end else if (grant_cpu) begin
         ram_addr_d = cpu_addr;
         cpu_wr_d   = cpu_we;
         if (cpu_we) begin
            ram_wdata_d = cpu_wdata;
            ram_we_d    = 1'b1;
         end
         state_d = S_C_ADDR;
      end

      if (grant_cpu || !cpu_req) begin
         streak_d = '0;
      end else if (grant_vid && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   // State and all registered outputs; reset clears everything at once.
   always_ff @(posedge clk1 or negedge clrn1) begin
      if (!clrn1) begin
         state_q     <= S_IDLE;
         streak_q    <= '0;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         vid_data_q  <= '0;
         cpu_rdata_q <= '0;
         cpu_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         vid_ack_q   <= vid_ack_d;
         cpu_ack_q   <= cpu_ack_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         vid_data_q  <= vid_data_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_wr_q    <= cpu_wr_d;
      end
   end

   assign vid_ack   = vid_ack_q;
   assign vid_data  = vid_data_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = !cpu_req || cpu_ack_q;
   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;

endmodule
